imm_decode_stage: RTL

- Registered, handshaked immediate-extraction stage for the decode pipeline.
- Takes a raw 32-bit instruction and selects the immediate format from the opcode, not from an externally supplied type.
- Produces an XLEN-wide sign-extended immediate, a format code and an illegal flag.
- Sits between fetch and the register-read/ALU-operand stage. A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/imm_decode_pkg.sv | 58 +++++
 rtl/imm_skid_buffer.sv | 50 +++++
 rtl/imm_decode_stage.sv | 34 +++
 3 files changed

// File: rtl/imm_decode_pkg.sv
// imm_decode_pkg: shared types, opcodes and immediate extraction (IMM_DECODE_ZICSR_EN adds fmt Z for CSR-immediate ops)
package imm_decode_pkg;
  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6
  } fmt_e;
  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  typedef struct packed {
    logic [63:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } imm_res_t;
  function automatic imm_res_t imm_extract(input logic [31:0] instr, input logic xlen_is_64);
    imm_res_t r;
    logic [6:0] op;
    logic s;
    logic is_i;
    logic csr_imm;
    op = instr[6:0];
    s = instr[31];
    is_i = (op == OP_LOAD) || (op == OP_IMM) || (op == OP_JALR) || (op == OP_SYSTEM) ||
           (op == OP_IMM32 && xlen_is_64);
`ifdef IMM_DECODE_ZICSR_EN
    csr_imm = (op == OP_SYSTEM) && instr[14];
`else
    csr_imm = 1'b0;
`endif
    r.illegal = !(is_i || op == OP_STORE || op == OP_BRANCH || op == OP_LUI ||
                  op == OP_AUIPC || op == OP_JAL || op == OP_REG);
    r.fmt = csr_imm ? FMT_Z :
            is_i ? FMT_I :
            op == OP_STORE ? FMT_S :
            op == OP_BRANCH ? FMT_B :
            (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
            op == OP_JAL ? FMT_J : FMT_R;
    case (r.fmt)
      FMT_I:   r.imm = {{52{s}}, instr[31:20]};
      FMT_S:   r.imm = {{52{s}}, instr[31:25], instr[11:7]};
      FMT_B:   r.imm = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   r.imm = {{32{s}}, instr[31:12], 12'b0};
      FMT_J:   r.imm = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   r.imm = {59'b0, instr[19:15]};
      default: r.imm = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/imm_skid_buffer.sv
// imm_skid_buffer: 2-entry valid/ready buffer, in_ready depends only on registered state
module imm_skid_buffer
  import imm_decode_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state_q, state_d;
  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  logic in_fire, out_fire, out_ld, skid_ld;
  assign in_ready = state_q != SKID_TWO;
  assign out_valid = state_q != SKID_EMPTY;
  assign out_data = out_q;
  // next state and register load enables; the output register refills from skid when draining TWO
  always_comb begin
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    state_d = flush ? SKID_EMPTY :
              state_q == SKID_EMPTY ? (in_fire ? SKID_ONE : SKID_EMPTY) :
              state_q == SKID_ONE ? (in_fire && !out_fire ? SKID_TWO :
                                     !in_fire && out_fire ? SKID_EMPTY : SKID_ONE) :
              (out_fire ? SKID_ONE : SKID_TWO);
    out_ld = !flush && (state_q == SKID_TWO ? out_fire :
                        in_fire && (state_q == SKID_EMPTY || out_fire));
    skid_ld = !flush && state_q == SKID_ONE && in_fire && !out_fire;
    out_d = state_q == SKID_TWO ? skid_q : in_data;
    skid_d = in_data;
  end
  // state and payload registers; payload only moves on a load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      if (out_ld) out_q <= out_d;
      if (skid_ld) skid_q <= skid_d;
    end
  end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: opcode-driven immediate decode feeding a skid buffer (IMM_DECODE_ZICSR_EN enables fmt Z)
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam int W = 32 + XLEN + 4;
  imm_res_t dec;
  logic [W-1:0] in_pay, out_pay;
  logic unused_imm;
  // decode before registering so both buffer entries hold finished fields
  always_comb dec = imm_extract(in_instr, XLEN == 64);
  assign unused_imm = ^dec.imm;
  assign in_pay = {in_instr, dec.imm[XLEN-1:0], dec.fmt, dec.illegal};
  assign {out_instr, out_imm, out_fmt, out_illegal} = out_pay;
  imm_skid_buffer #(.W(W)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_pay),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_pay)
  );
endmodule
